// File: rtl/log_uart_pkg.sv
// rtl/log_uart_pkg.sv - shared types, frame constants and byte builder for log_uart_tx (option macro: LOG_UART_TX_TIMESTAMP_EN)
package log_uart_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

`ifdef LOG_UART_TX_TIMESTAMP_EN
  localparam int FRAME_LEN = 9;
`else
  localparam int FRAME_LEN = 7;
`endif

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  typedef struct packed {
    logic [7:0]  id;
`ifdef LOG_UART_TX_TIMESTAMP_EN
    logic [15:0] ts;
`endif
    logic [31:0] data;
  } log_rec_t;

  // Byte idx of the frame for a record: sync, body bytes LSB first, then XOR of the body.
  function automatic logic [7:0] frame_byte(input log_rec_t rec, input logic [3:0] idx);
    logic [8*(FRAME_LEN-2)-1:0] body;
    logic [7:0] chk;
`ifdef LOG_UART_TX_TIMESTAMP_EN
    body = {rec.data, rec.ts, rec.id};
`else
    body = {rec.data, rec.id};
`endif
    chk = 8'h00;
    for (int i = 0; i < FRAME_LEN - 2; i++) begin
      chk = chk ^ body[8*i +: 8];
    end
    frame_byte = 8'hFF;
    if (idx == 4'd0) begin
      frame_byte = SYNC_BYTE;
    end else if (int'(idx) == FRAME_LEN - 1) begin
      frame_byte = chk;
    end else if (int'(idx) < FRAME_LEN - 1) begin
      frame_byte = body[8*(int'(idx)-1) +: 8];
    end
  endfunction

endpackage

// File: rtl/log_fifo.sv
// rtl/log_fifo.sv - synchronous record FIFO with full/empty flags for log_uart_tx
module log_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & !full;
  assign do_pop  = pop & !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; a flush just clears them.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/log_uart_tx.sv
// rtl/log_uart_tx.sv - debug-log record FIFO plus 8N1 checksummed frame serializer (option macro: LOG_UART_TX_TIMESTAMP_EN)
module log_uart_tx
  import log_uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        log_valid_i,
  output logic        log_ready_o,
  input  logic [7:0]  log_id_i,
  input  logic [31:0] log_data_i,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  tx_state_t        state;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [3:0]       byte_idx;
  logic [7:0]       shift_reg;
  log_rec_t         frame_rec;
  log_rec_t         push_rec;
  log_rec_t         fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic             div_done;

  // Ready ignores a same-cycle pop, so a full FIFO stalls one extra cycle.
  assign log_ready_o = !fifo_full & !reset_i;
  assign fifo_push   = log_valid_i & log_ready_o;
  assign fifo_pop    = (state == IDLE) & !fifo_empty;
  assign busy_o      = (state != IDLE) | !fifo_empty;
  assign div_done    = (div_cnt == DIV_W'(CLK_DIV - 1));

`ifdef LOG_UART_TX_TIMESTAMP_EN
  logic [15:0] ts_cnt;

  // Free-running cycle counter stamped onto each accepted record.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      ts_cnt <= 16'h0000;
    end else begin
      ts_cnt <= ts_cnt + 16'd1;
    end
  end
`endif

  // Assemble the incoming record from the port fields.
  always_comb begin
    push_rec      = '0;
    push_rec.id   = log_id_i;
    push_rec.data = log_data_i;
`ifdef LOG_UART_TX_TIMESTAMP_EN
    push_rec.ts   = ts_cnt;
`endif
  end

  log_fifo #(
    .WIDTH($bits(log_rec_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_i(reset_i),
    .push   (fifo_push),
    .wdata  (push_rec),
    .pop    (fifo_pop),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Serializer FSM; tx_o is registered from the current state so the line lags the state by one cycle.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      byte_idx  <= '0;
      shift_reg <= '0;
      frame_rec <= '0;
      tx_o      <= 1'b1;
    end else begin
      case (state)
        START:   tx_o <= 1'b0;
        DATA:    tx_o <= shift_reg[0];
        default: tx_o <= 1'b1;
      endcase

      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            frame_rec <= fifo_rdata;
            byte_idx  <= '0;
            div_cnt   <= '0;
            state     <= START;
          end
        end
        START: begin
          if (div_done) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= frame_byte(frame_rec, byte_idx);
            state     <= DATA;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        DATA: begin
          if (div_done) begin
            div_cnt   <= '0;
            shift_reg <= {1'b0, shift_reg[7:1]};
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        STOP: begin
          if (div_done) begin
            div_cnt <= '0;
            if (byte_idx == 4'(FRAME_LEN - 1)) begin
              byte_idx <= '0;
              state    <= IDLE;
            end else begin
              byte_idx <= byte_idx + 4'd1;
              state    <= START;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
